// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: state encoding, display-source codes and default counter width
package reaction_game_pkg;
  localparam int TIME_W_DEFAULT = 14;
  typedef enum logic [2:0] {IDLE, WAIT, TIMING, RESULT, FAULT} state_t;
  localparam logic [1:0] DISP_SCROLL = 2'd0;
  localparam logic [1:0] DISP_LIVE   = 2'd1;
  localparam logic [1:0] DISP_BEST   = 2'd2;
  localparam logic [1:0] DISP_FAULT  = 2'd3;
endpackage

// File: rtl/reaction_game_ctrl_sync.sv
// press_edge_sync: 2-flop synchronizer for a button level plus one-clock rising-edge pulse
module press_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clock)
    if (reset) sh <= '0;
    else sh <= {sh[1:0], level};
  assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: reaction-time game sequencer (delay, timing, best time, display select).
// Define REACT_CHEAT_DETECT_EN to send a react press during WAIT to a timed FAULT state.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int TIME_W        = TIME_W_DEFAULT,
  parameter int MIN_DELAY_MS  = 1000,
  parameter int TIMEOUT_MS    = 9999,
  parameter int FAULT_HOLD_MS = 2000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1ms,
  input  logic              start_press,
  input  logic              react_press,
  input  logic [11:0]       random,
  input  logic              show_high,
  output logic              cu_clear,
  output logic              cu_en,
  output logic              hs_update,
  output logic [TIME_W-1:0] elapsed_ms,
  output logic [TIME_W-1:0] best_ms,
  output logic [1:0]        disp_sel,
  output logic              led_wait,
  output logic              led_go,
  output logic              timed_out
);
  if (MIN_DELAY_MS < 1 || TIMEOUT_MS >= 2**TIME_W || FAULT_HOLD_MS < 1 ||
      FAULT_HOLD_MS >= 2**TIME_W || MIN_DELAY_MS + 4095 >= 2**TIME_W) begin : g_bad_cfg
    $error("reaction_game_ctrl: parameter out of range");
  end
  state_t state, state_n;
  logic start, react;
  logic timed_out_n, cu_clear_n, hs_update_n;
  logic [TIME_W-1:0] delay, delay_n, elapsed_n, best_n, delay_load, elapsed_inc;
`ifdef REACT_CHEAT_DETECT_EN
  logic [TIME_W-1:0] fault_cnt, fault_n, fault_inc;
  assign fault_inc = &fault_cnt ? fault_cnt : fault_cnt + TIME_W'(1);
`endif
  press_edge_sync u_start (.clock(clock), .reset(reset), .level(start_press), .pulse(start));
  press_edge_sync u_react (.clock(clock), .reset(reset), .level(react_press), .pulse(react));
  assign delay_load  = TIME_W'(MIN_DELAY_MS) + TIME_W'(random);
  assign elapsed_inc = &elapsed_ms ? elapsed_ms : elapsed_ms + TIME_W'(1);
  always_comb begin
    state_n     = state;
    delay_n     = delay;
    elapsed_n   = elapsed_ms;
    best_n      = best_ms;
    timed_out_n = timed_out;
    cu_clear_n  = 1'b0;
    hs_update_n = 1'b0;
`ifdef REACT_CHEAT_DETECT_EN
    fault_n     = fault_cnt;
`endif
    case (state)
      IDLE:
        if (start) begin
          delay_n = delay_load;
          state_n = WAIT;
        end
      WAIT:
`ifdef REACT_CHEAT_DETECT_EN
        if (react) begin
          fault_n = '0;
          state_n = FAULT;
        end else
`endif
        if (tick_1ms) begin
          delay_n = (delay == '0) ? delay : delay - TIME_W'(1);
          if (delay <= TIME_W'(1)) begin
            elapsed_n  = '0;
            cu_clear_n = 1'b1;
            state_n    = TIMING;
          end
        end
      TIMING:
        // react has priority: a same-cycle tick or timeout must not alter the frozen time
        if (react) begin
          state_n = RESULT;
          if (elapsed_ms < best_ms) begin
            best_n      = elapsed_ms;
            hs_update_n = 1'b1;
          end
        end else if (tick_1ms) begin
          elapsed_n = elapsed_inc;
          if (elapsed_inc >= TIME_W'(TIMEOUT_MS)) begin
            timed_out_n = 1'b1;
            state_n     = RESULT;
          end
        end
      RESULT:
        if (start) begin
          timed_out_n = 1'b0;
          delay_n     = delay_load;
          state_n     = WAIT;
        end
`ifdef REACT_CHEAT_DETECT_EN
      FAULT:
        if (tick_1ms) begin
          fault_n = fault_inc;
          if (fault_inc >= TIME_W'(FAULT_HOLD_MS)) state_n = IDLE;
        end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE;
      delay      <= '0;
      elapsed_ms <= '0;
      best_ms    <= '1;
      timed_out  <= 1'b0;
      cu_clear   <= 1'b0;
      hs_update  <= 1'b0;
`ifdef REACT_CHEAT_DETECT_EN
      fault_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      delay      <= delay_n;
      elapsed_ms <= elapsed_n;
      best_ms    <= best_n;
      timed_out  <= timed_out_n;
      cu_clear   <= cu_clear_n;
      hs_update  <= hs_update_n;
`ifdef REACT_CHEAT_DETECT_EN
      fault_cnt  <= fault_n;
`endif
    end
  assign led_wait = state == WAIT;
  assign led_go   = state == TIMING;
  assign cu_en    = state == TIMING;
  assign disp_sel = state == FAULT ? DISP_FAULT :
                    state == IDLE ? (show_high ? DISP_BEST : DISP_SCROLL) :
                    state == RESULT ? (show_high ? DISP_BEST : DISP_LIVE) : DISP_LIVE;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: directed reaction-game scenarios checked each cycle against a behavioural model
`timescale 1ns/1ps
module tb_reaction_game_ctrl;
  localparam int W = 14, MIN_D = 4, TMO = 50, HOLD = 3, NONE = (1 << W) - 1;
  localparam int P_IDLE = 0, P_WAIT = 1, P_TIME = 2, P_RES = 3, P_FAULT = 4;
`ifdef REACT_CHEAT_DETECT_EN
  localparam bit CHEAT = 1'b1;
`else
  localparam bit CHEAT = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, tick_1ms = 1'b0;
  logic start_press = 1'b0, react_press = 1'b0, show_high = 1'b0;
  logic [11:0] random = '0;
  logic cu_clear, cu_en, hs_update, led_wait, led_go, timed_out;
  logic [W-1:0] elapsed_ms, best_ms;
  logic [1:0] disp_sel;
  int compared = 0, mismatched = 0;
  int n_wait_ticks = 0, n_clear = 0, n_hs = 0;
  bit prev_wait = 1'b0;
  int m_phase = P_IDLE, m_rem = 0, m_el = 0, m_best = NONE, m_fcnt = 0;
  bit m_to = 1'b0, m_clear = 1'b0, m_hs = 1'b0;
  bit [2:0] h_start = '0, h_react = '0;

  reaction_game_ctrl #(.TIME_W(W), .MIN_DELAY_MS(MIN_D), .TIMEOUT_MS(TMO), .FAULT_HOLD_MS(HOLD)) dut (
    .clock(clock), .reset(reset), .tick_1ms(tick_1ms), .start_press(start_press),
    .react_press(react_press), .random(random), .show_high(show_high),
    .cu_clear(cu_clear), .cu_en(cu_en), .hs_update(hs_update), .elapsed_ms(elapsed_ms),
    .best_ms(best_ms), .disp_sel(disp_sel), .led_wait(led_wait), .led_go(led_go),
    .timed_out(timed_out));

  always #5 clock = ~clock;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clock);
      c = (c == 9) ? 0 : c + 1;
      tick_1ms = (c == 0);
    end
  end

  // Game rules: a press acts on the third clock edge after the button level rises.
  always @(posedge clock) begin
    bit sp, rp;
    sp = h_start[1] & ~h_start[2];
    rp = h_react[1] & ~h_react[2];
    m_clear = 1'b0;
    m_hs = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_rem = 0; m_el = 0; m_best = NONE; m_to = 1'b0; m_fcnt = 0;
      h_start = '0; h_react = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (sp) begin m_rem = MIN_D + int'(random); m_phase = P_WAIT; end
        P_WAIT:
          if (CHEAT && rp) begin m_phase = P_FAULT; m_fcnt = 0; end
          else if (tick_1ms) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_phase = P_TIME; m_el = 0; m_clear = 1'b1; end
          end
        P_TIME:
          if (rp) begin
            m_phase = P_RES;
            if (m_el < m_best) begin m_best = m_el; m_hs = 1'b1; end
          end else if (tick_1ms) begin
            m_el = m_el + 1;
            if (m_el == TMO) begin m_phase = P_RES; m_to = 1'b1; end
          end
        P_RES: if (sp) begin m_to = 1'b0; m_rem = MIN_D + int'(random); m_phase = P_WAIT; end
        default:
          if (tick_1ms) begin
            m_fcnt = m_fcnt + 1;
            if (m_fcnt == HOLD) m_phase = P_IDLE;
          end
      endcase
      h_start = {h_start[1:0], start_press};
      h_react = {h_react[1:0], react_press};
    end
  end

  function automatic logic [1:0] exp_disp();
    case (m_phase)
      P_IDLE:  return show_high ? 2'd2 : 2'd0;
      P_RES:   return show_high ? 2'd2 : 2'd1;
      P_FAULT: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  always @(posedge clock) begin
    logic [35:0] act, exp;
    #1;
    exp = {m_clear, m_phase == P_TIME, m_hs, m_phase == P_WAIT, m_phase == P_TIME, m_to,
           exp_disp(), W'(m_el), W'(m_best)};
    act = {cu_clear, cu_en, hs_update, led_wait, led_go, timed_out, disp_sel, elapsed_ms, best_ms};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, act, exp);
    end
    if (tick_1ms && prev_wait) n_wait_ticks++;
    prev_wait = led_wait;
    n_clear += int'(cu_clear);
    n_hs += int'(hs_update);
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input bit s, input bit r);
    @(negedge clock);
    start_press = s;
    react_press = r;
    repeat (4) @(negedge clock);
    start_press = 1'b0;
    react_press = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clock);
      if (tick_1ms) k++;
    end
  endtask

  task automatic wait_go(input string name, input bit lvl);
    int k;
    k = 0;
    while (led_go !== lvl && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL %s: led_go never reached %0d", name, lvl);
    end
  endtask

  task automatic game(input int rnd, input int react_at);
    random = 12'(rnd);
    press(1'b1, 1'b0);
    wait_go("go_rise", 1'b1);
    if (react_at >= 0) begin
      wait_ticks(react_at);
      press(1'b0, 1'b1);
    end else wait_go("go_fall", 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_best", int'(best_ms), NONE);
    chk("rst_led_wait", int'(led_wait), 0);
    show_high = 1'b1;
    @(negedge clock);
    chk("idle_show_high", int'(disp_sel), 2);
    show_high = 1'b0;
    n_wait_ticks = 0; n_clear = 0; n_hs = 0;
    game(3, 12);
    chk("g1_wait_ticks", n_wait_ticks, 7);
    chk("g1_clear_pulses", n_clear, 1);
    chk("g1_elapsed", int'(elapsed_ms), 12);
    chk("g1_best", int'(best_ms), 12);
    chk("g1_hs_pulses", n_hs, 1);
    n_hs = 0;
    game(1, 20);
    chk("g2_elapsed", int'(elapsed_ms), 20);
    chk("g2_best", int'(best_ms), 12);
    show_high = 1'b1;
    repeat (2) @(negedge clock);
    chk("g2_show_high", int'(disp_sel), 2);
    show_high = 1'b0;
    game(0, 12);
    chk("g3_tie_best", int'(best_ms), 12);
    chk("g2g3_no_hs", n_hs, 0);
    game(2, -1);
    chk("g4_elapsed", int'(elapsed_ms), TMO);
    chk("g4_timed_out", int'(timed_out), 1);
    chk("g4_no_hs", n_hs, 0);
    press(1'b1, 1'b0);
    chk("g4_restart_to", int'(timed_out), 0);
    chk("g4_restart_wait", int'(led_wait), 1);
    wait_ticks(2);
    press(1'b0, 1'b1);
`ifdef REACT_CHEAT_DETECT_EN
    chk("cheat_disp", int'(disp_sel), 3);
    wait_ticks(4);
    chk("cheat_idle_wait", int'(led_wait), 0);
    chk("cheat_idle_disp", int'(disp_sel), 0);
    chk("cheat_best_kept", int'(best_ms), 12);
`else
    chk("early_react_wait", int'(led_wait), 1);
    wait_go("g5_go", 1'b1);
    wait_ticks(5);
    press(1'b0, 1'b1);
    chk("g5_elapsed", int'(elapsed_ms), 5);
    chk("g5_best", int'(best_ms), 5);
    chk("g5_hs_pulses", n_hs, 1);
`endif
    random = 12'd0;
    press(1'b1, 1'b0);
    wait_go("g6_go", 1'b1);
    wait_ticks(3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_go", int'(led_go), 0);
    chk("mid_rst_best", int'(best_ms), NONE);
    chk("mid_rst_elapsed", int'(elapsed_ms), 0);
    chk("mid_rst_disp", int'(disp_sel), 0);
    chk("mid_rst_cu_en", int'(cu_en), 0);
    press(1'b1, 1'b1);
    chk("both_press_wait", int'(led_wait), 1);
    wait_ticks(2);
    chk("both_press_still_wait", int'(led_wait), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Sequencer for the reaction-time game datapath: idle/scroll display, random pre-start delay, millisecond timing, result/high-score hold.
- Owns the delay and elapsed counters and the best-time register.
- Drives enables to the BCD count-up/decoder path and the display-source select to the seven-segment muxes.
- Sits between the 1 kHz tick divider, the LFSR and the display mux chain.

Parameters:
TIME_W, 14, width of delay, elapsed and best counters (binary ms).
MIN_DELAY_MS, 1000, added to the random value to form the pre-start delay; must be >=1.
TIMEOUT_MS, 9999, elapsed value that ends timing without a valid reaction.
FAULT_HOLD_MS, 2000, ticks spent in FAULT before returning to IDLE.

Ports:
clock  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high; all state to reset values on the next clock edge.
tick_1ms  in  1  one-clock pulse every 1 ms, synchronous to clock.
start_press  in  1  start button level, active-high, debounced, asynchronous.
react_press  in  1  reaction button level, active-high, debounced, asynchronous.
random  in  12  LFSR value, sampled on entry to WAIT.
show_high  in  1  switch level: display best time instead of live/scroll in IDLE and RESULT.
cu_clear  out  1  one-cycle clear pulse to the BCD count-up.
cu_en  out  1  count-up enable, gated with tick_1ms downstream.
hs_update  out  1  one-cycle pulse when best_ms is rewritten.
elapsed_ms  out  TIME_W  current or latched reaction time.
best_ms  out  TIME_W  best time; all-ones means none.
disp_sel  out  2  0 scroll, 1 live, 2 best, 3 fault.
led_wait  out  1  high in WAIT.
led_go  out  1  high in TIMING.
timed_out  out  1  high in RESULT when it was entered by timeout.

Behaviour:
- Input conditioning: start_press and react_press pass through a 2-flop synchronizer, then rising-edge detect. "Press" below means that one-cycle edge. Press-to-action latency is 3 clocks.
- Reset values: state IDLE; delay, elapsed, fault counters 0; best_ms all-ones; all pulses and LEDs 0; timed_out 0; disp_sel 0.
- State encoding lives in the package: IDLE, WAIT, TIMING, RESULT, FAULT.
- IDLE:
  - disp_sel = show_high ? 2 : 0.
  - On start press: load delay = MIN_DELAY_MS + random (zero-extended), then go to WAIT.
- WAIT:
  - Each tick decrements delay.
  - The tick that takes delay from 1 to 0 moves to TIMING. WAIT therefore lasts exactly the loaded value in ticks.
  - On TIMING entry: cu_clear pulses and elapsed is cleared to 0.
  - disp_sel = 1.
- TIMING:
  - cu_en = 1; each tick increments elapsed.
  - On react press: go to RESULT with elapsed frozen.
  - If elapsed reaches TIMEOUT_MS: go to RESULT with timed_out = 1.
  - React press wins over a same-cycle tick (elapsed is not incremented) and over timeout.
- RESULT entry:
  - If !timed_out and elapsed < best: best <= elapsed and hs_update pulses for one cycle on the entry edge.
  - Ties do not update best.
- RESULT:
  - cu_en = 0; disp_sel = show_high ? 2 : 1.
  - React presses are ignored.
  - On start press: clear timed_out, reload delay, go to WAIT.
- Simultaneous start and react presses: start wins in IDLE and RESULT. start is ignored in WAIT, TIMING and FAULT.
- Reset mid-game: returns to IDLE within one clock. best_ms is also cleared.
- All counters saturate. No wrap is possible because TIMEOUT_MS < 2^TIME_W.

Optional Feature:
REACT_CHEAT_DETECT_EN
- Defined: a react press in WAIT moves to FAULT.
  - In FAULT: disp_sel = 3; the fault counter counts FAULT_HOLD_MS ticks, then returns to IDLE.
  - best_ms is untouched.
- Undefined: react presses in WAIT are ignored; the FAULT state and its counter are not generated; disp_sel never equals 3.

Decomposition:
- Package reaction_game_pkg: state enum, disp_sel encodings (DISP_SCROLL, DISP_LIVE, DISP_BEST, DISP_FAULT), TIME_W default.
- One sub-module: press_edge_sync (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Test Plan:
Directed scenarios use MIN_DELAY_MS=4, TIMEOUT_MS=50, FAULT_HOLD_MS=3, tick every 10 clocks.
1. Start press, random=3 -> led_wait for exactly 7 ticks; cu_clear pulses once; led_go rises.
2. React press after 12 ticks of TIMING -> RESULT with elapsed_ms=12; hs_update pulses; best_ms=12.
3. Second game, react at 20 -> best_ms stays 12 with no hs_update. Third game, react at 12 -> no update on a tie.
4. No react in TIMING -> elapsed_ms=50, timed_out=1, no hs_update. Start press -> timed_out=0 and state WAIT.
5. React press during WAIT:
   - with REACT_CHEAT_DETECT_EN: disp_sel=3 for 3 ticks, then IDLE.
   - without it: stays in WAIT and timing proceeds normally.
6. reset asserted mid-TIMING -> next clock IDLE, best_ms all-ones, all outputs at reset values. Start and react pressed in the same cycle in IDLE -> WAIT.
